// File: rtl/fir_stream_pkg.sv
// Shared types and arithmetic helpers for the streaming FIR filter.
package fir_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FIN,
    HOLD
  } state_t;

  // Working width for the rounding helper; comfortably wider than any accumulator in use.
  localparam int ACC_MAX = 96;

  // Accumulator width that can hold a full NTAPS-term dot product without overflow.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

  // Round half up, arithmetic shift right, then clamp into a signed dw-bit range.
  function automatic logic signed [ACC_MAX-1:0] round_sat(
    input logic signed [ACC_MAX-1:0] acc,
    input int                        shift,
    input int                        dw
  );
    logic signed [ACC_MAX-1:0] one;
    logic signed [ACC_MAX-1:0] half;
    logic signed [ACC_MAX-1:0] r;
    logic signed [ACC_MAX-1:0] hi;
    logic signed [ACC_MAX-1:0] lo;
    logic signed [ACC_MAX-1:0] res;
    one    = '0;
    one[0] = 1'b1;
    half   = '0;
    if (shift > 0) half = one <<< (shift - 1);
    r  = (acc + half) >>> shift;
    hi = (one <<< (dw - 1)) - one;
    lo = -(one <<< (dw - 1));
    res = r;
    if (r > hi) res = hi;
    if (r < lo) res = lo;
    return res;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational rounding, scaling and saturation of the final accumulator value.
module fir_round_sat
  import fir_stream_pkg::*;
#(
  parameter int ACCW      = 36,
  parameter int DW        = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACCW-1:0] acc,
  output logic signed [DW-1:0]   result
);

  logic signed [ACC_MAX-1:0] wide;
  logic signed [ACC_MAX-1:0] clamped;

  // Sign-extend into the helper's working width, round/saturate, keep the low DW bits.
  always_comb begin
    wide    = {{(ACC_MAX - ACCW){acc[ACCW-1]}}, acc};
    clamped = round_sat(wide, OUT_SHIFT, DW);
    result  = DW'(clamped);
  end

endmodule

// File: rtl/fir_stream.sv
// Time-multiplexed FIR: one sequential MAC per accepted sample, valid/ready on both sides.
module fir_stream
  import fir_stream_pkg::*;
#(
  parameter int NTAPS     = 16,
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]       coef_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DW-1:0]       in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DW-1:0]       out_data,
  output logic                       busy
);

  localparam int AW   = $clog2(NTAPS);
  localparam int ACCW = acc_width(DW, CW, NTAPS);
  localparam int PW   = DW + CW;

  state_t state;
  state_t state_next;

  logic signed [DW-1:0]   x [NTAPS];
  logic signed [CW-1:0]   c [NTAPS];
  logic signed [ACCW-1:0] acc;
  logic [AW-1:0]          idx;
  logic signed [PW-1:0]   prod;
  logic signed [DW-1:0]   rs_data;

  logic                   accept;
  logic                   last_tap;
  logic                   coef_ok;
  logic                   pend_valid;
  logic [AW-1:0]          pend_addr;
  logic signed [CW-1:0]   pend_data;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign last_tap = (idx == AW'(NTAPS - 1));
  assign coef_ok  = coef_we && !busy && (int'(coef_addr) < NTAPS);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept, walk all taps, finalise, then wait for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MAC;
      MAC:     if (last_tap) state_next = FIN;
      FIN:     state_next = HOLD;
      HOLD:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One product per MAC cycle, both operands sign-extended to the full product width.
  always_comb begin
    prod = PW'(x[idx]) * PW'(c[idx]);
  end

  // Sample delay line shifts in the newest sample on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
    end else if (accept) begin
      x[0] <= in_data;
      for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
    end
  end

  // Coefficient bank; a write landing on the accept edge is parked until the MAC pass is done.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) c[k] <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      if (coef_ok && accept) begin
        pend_valid <= 1'b1;
        pend_addr  <= coef_addr;
        pend_data  <= coef_data;
      end else if (coef_ok) begin
        c[coef_addr] <= coef_data;
      end
      if (state == FIN && pend_valid) begin
        c[pend_addr] <= pend_data;
        pend_valid   <= 1'b0;
      end
    end
  end

  // Accumulator and tap index: cleared on accept, stepped once per MAC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      acc <= '0;
      idx <= '0;
    end else if (state == MAC) begin
      acc <= acc + ACCW'(prod);
      idx <= idx + AW'(1);
    end
  end

  fir_round_sat #(
    .ACCW      (ACCW),
    .DW        (DW),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc    (acc),
    .result (rs_data)
  );

  // Output register: loaded on the finalise edge, held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (state == FIN) begin
      out_valid <= 1'b1;
      out_data  <= rs_data;
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_stream.sv
// Scoreboard-driven testbench for fir_stream (main instance OUT_SHIFT=0, second instance OUT_SHIFT=1).
module tb_fir_stream;

  localparam int NTAPS = 16;
  localparam int DW    = 16;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst;

  logic               coef_we;
  logic [3:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               busy;

  logic               r_coef_we;
  logic [3:0]         r_coef_addr;
  logic signed [15:0] r_coef_data;
  logic               r_in_valid;
  logic               r_in_ready;
  logic signed [15:0] r_in_data;
  logic               r_out_valid;
  logic               r_out_ready;
  logic signed [15:0] r_out_data;
  logic               r_busy;

  fir_stream #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst(rst),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  fir_stream #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .OUT_SHIFT(1)) dut_sh (
    .clk(clk), .rst(rst),
    .coef_we(r_coef_we), .coef_addr(r_coef_addr), .coef_data(r_coef_data),
    .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
    .busy(r_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  longint             xm [NTAPS];
  longint             cm [NTAPS];
  logic signed [15:0] exp_q [$];
  int                 accept_cyc;

  function automatic logic signed [15:0] model_out();
    longint s;
    s = 0;
    for (int k = 0; k < NTAPS; k++) s += xm[k] * cm[k];
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NTAPS; k++) begin
      xm[k] = 0;
      cm[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    r_coef_we = 1'b0; r_coef_addr = '0; r_coef_data = '0;
    r_in_valid = 1'b0; r_in_data = '0; r_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic write_coef(input int addr, input int val);
    bit was_idle;
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 16'(val);
    was_idle  = !busy;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    if (was_idle) cm[addr] = val;
  endtask

  task automatic send_sample(input int val);
    int guard;
    in_valid = 1'b1;
    in_data  = 16'(val);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    for (int k = NTAPS - 1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = val;
    exp_q.push_back(model_out());
  endtask

  task automatic collect(output logic signed [15:0] d, output int lat, output bit timeout);
    timeout = 1'b1;
    d = '0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        d = out_data;
        lat = cyc - accept_cyc;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b expected 0", busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'sd0) $display("[TB] FAIL reset_out_data got %0d expected 0", out_data); else n_pass++;
  endtask

  task automatic test_running_sum();
    logic signed [15:0] d;
    logic signed [15:0] e;
    int lat;
    bit to;
    int prev_acc;
    do_reset();
    for (int k = 0; k < NTAPS; k++) write_coef(k, 1);
    prev_acc = -1;
    for (int n = 1; n <= 16; n++) begin
      send_sample(n);
      n_checks++;
      if (prev_acc >= 0 && (accept_cyc - prev_acc) !== 19)
        $display("[TB] FAIL run_sum_rate[%0d] got %0d cycles expected 19", n, accept_cyc - prev_acc);
      else n_pass++;
      prev_acc = accept_cyc;
      collect(d, lat, to);
      e = exp_q.pop_front();
      n_checks++; if (to !== 1'b0) $display("[TB] FAIL run_sum_timeout[%0d] got timeout expected out_valid", n); else n_pass++;
      n_checks++; if (d !== e) $display("[TB] FAIL run_sum_data[%0d] got %0d expected %0d", n, d, e); else n_pass++;
      n_checks++; if (lat !== 17) $display("[TB] FAIL run_sum_latency[%0d] got %0d expected 17", n, lat); else n_pass++;
    end
  endtask

  task automatic test_impulse();
    logic signed [15:0] d;
    logic signed [15:0] e;
    int lat;
    bit to;
    do_reset();
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    for (int n = 0; n < 17; n++) begin
      send_sample(n == 0 ? 1 : 0);
      collect(d, lat, to);
      e = exp_q.pop_front();
      n_checks++; if (to !== 1'b0 || d !== e) $display("[TB] FAIL impulse[%0d] got %0d (timeout=%0d) expected %0d", n, d, to, e); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] d;
    logic signed [15:0] e;
    int lat;
    bit to;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int k = 0; k < NTAPS; k++) write_coef(k, 32767);
      for (int n = 0; n < 3; n++) begin
        send_sample(pass == 0 ? 32767 : -32768);
        collect(d, lat, to);
        e = exp_q.pop_front();
        n_checks++; if (to !== 1'b0 || d !== e) $display("[TB] FAIL saturate_%s[%0d] got %0d expected %0d", pass == 0 ? "pos" : "neg", n, d, e); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] d0;
    logic signed [15:0] e;
    int guard;
    do_reset();
    write_coef(0, 5);
    write_coef(1, -3);
    out_ready = 1'b0;
    send_sample(7);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    d0 = out_data;
    e = exp_q.pop_front();
    n_checks++; if (out_valid !== 1'b1 || d0 !== e) $display("[TB] FAIL hold_first got %0d (valid=%b) expected %0d", d0, out_valid, e); else n_pass++;
    in_valid = 1'b1;
    in_data  = 16'sd100;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== d0 || in_ready !== 1'b0)
        $display("[TB] FAIL hold_stable[%0d] got valid=%b data=%0d in_ready=%b expected 1/%0d/0", i, out_valid, out_data, in_ready, d0);
      else n_pass++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL hold_release got valid=%b in_ready=%b expected 0/1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_write_while_busy();
    logic signed [15:0] d;
    logic signed [15:0] e;
    int lat;
    bit to;
    send_sample(2);
    collect(d, lat, to);
    e = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || d !== e) $display("[TB] FAIL ignored_input got %0d expected %0d", d, e); else n_pass++;
    send_sample(4);
    n_checks++; if (busy !== 1'b1) $display("[TB] FAIL busy_in_mac got %b expected 1", busy); else n_pass++;
    write_coef(0, 1000);
    write_coef(1, 1000);
    collect(d, lat, to);
    e = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || d !== e) $display("[TB] FAIL busy_write_same got %0d expected %0d", d, e); else n_pass++;
    send_sample(1);
    collect(d, lat, to);
    e = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || d !== e) $display("[TB] FAIL busy_write_next got %0d expected %0d", d, e); else n_pass++;
  endtask

  task automatic test_same_edge_write();
    logic signed [15:0] d;
    logic signed [15:0] e;
    int lat;
    bit to;
    coef_we   = 1'b1;
    coef_addr = 4'd1;
    coef_data = 16'sd10;
    send_sample(3);
    coef_we = 1'b0;
    cm[1] = 10;
    collect(d, lat, to);
    e = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || d !== e) $display("[TB] FAIL same_edge_old got %0d expected %0d", d, e); else n_pass++;
    send_sample(0);
    collect(d, lat, to);
    e = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || d !== e) $display("[TB] FAIL same_edge_new got %0d expected %0d", d, e); else n_pass++;
  endtask

  task automatic test_reset_mid_mac();
    logic signed [15:0] d;
    logic signed [15:0] e;
    int lat;
    bit to;
    bit seen;
    send_sample(9);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL mid_reset_idle got in_ready=%b busy=%b expected 1/0", in_ready, busy); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("[TB] FAIL mid_reset_no_output got out_valid=1 expected 0"); else n_pass++;
    send_sample(5);
    collect(d, lat, to);
    e = exp_q.pop_front();
    n_checks++; if (to !== 1'b0 || d !== e) $display("[TB] FAIL mid_reset_zero got %0d expected %0d", d, e); else n_pass++;
  endtask

  task automatic test_rounding();
    logic signed [15:0] q2 [$];
    logic signed [15:0] e;
    int in_tab [4];
    int ex_tab [4];
    int guard;
    in_tab = '{3, -3, 4, -1};
    ex_tab = '{2, -1, 2, 0};
    do_reset();
    r_coef_we   = 1'b1;
    r_coef_addr = 4'd0;
    r_coef_data = 16'sd1;
    @(posedge clk);
    #1;
    r_coef_we = 1'b0;
    for (int n = 0; n < 4; n++) begin
      r_in_valid = 1'b1;
      r_in_data  = 16'(in_tab[n]);
      q2.push_back(16'(ex_tab[n]));
      guard = 0;
      while (!r_in_ready && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
      @(posedge clk);
      #1;
      r_in_valid = 1'b0;
      guard = 0;
      while (!r_out_valid && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
      e = q2.pop_front();
      n_checks++;
      if (r_out_valid !== 1'b1 || r_out_data !== e)
        $display("[TB] FAIL round[%0d] in=%0d got %0d (valid=%b) expected %0d", n, in_tab[n], r_out_data, r_out_valid, e);
      else n_pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d expected bench completion", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting fir_stream bench");
    test_reset();
    test_running_sum();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_write_while_busy();
    test_same_edge_write();
    test_reset_mid_mac();
    test_rounding();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_stream.md
Name: fir_stream

Overview:
Parametrised, time-multiplexed FIR filter and the successor to the fixed 16-tap `fir`. It holds an NTAPS-deep signed sample delay line and a randomly addressable coefficient bank. Each accepted sample is processed by a single sequential MAC. Results are rounded, shifted and saturated, then returned over a valid/ready output handshake. The block sits between a sample source and a downstream consumer that can apply backpressure.

Parameters:
NTAPS, 16, number of taps (>=2)
DW, 16, signed sample and output width
CW, 16, signed coefficient width
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0..CW+$clog2(NTAPS))

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(NTAPS)  tap index written
coef_data  in  CW  signed coefficient value
in_valid  in  1  sample offered
in_ready  out  1  block can accept a sample
in_data  in  DW  signed sample
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  DW  signed filtered result
busy  out  1  high in any state other than IDLE

Behaviour:
- Accumulator width ACCW = DW+CW+$clog2(NTAPS), signed. No internal overflow is possible.
- FSM states:
  - IDLE -> MAC on in_valid&&in_ready.
  - MAC -> FIN after NTAPS cycles.
  - FIN -> HOLD (one cycle).
  - HOLD -> IDLE on out_valid&&out_ready.
- in_ready = (state==IDLE). busy = (state!=IDLE).
- Accept edge:
  - Delay line shifts: x[0]<=in_data, x[k]<=x[k-1].
  - acc<=0, idx<=0.
- MAC cycle i (i=0..NTAPS-1): acc<=acc+x[i]*c[i], idx<=idx+1. The cycle with idx==NTAPS-1 moves to FIN.
- FIN edge:
  - Rounding: r = (acc + (OUT_SHIFT>0 ? 1<<(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT.
  - Saturation: out_data <= r clamped to [-2^(DW-1), 2^(DW-1)-1].
  - out_valid<=1.
- Latency: out_valid rises NTAPS+1 edges after the accepting edge.
- HOLD: out_valid and out_data stay stable until out_ready. On the handshake edge out_valid<=0 and state<=IDLE. The next sample can be accepted on the following cycle.
- Peak throughput: one sample per NTAPS+3 cycles.
- out_ready while out_valid==0 has no effect. in_valid while in_ready==0 is ignored; the source must hold the sample until accepted.
- Coefficient writes:
  - coef_we is honoured only when busy==0: c[coef_addr]<=coef_data.
  - Writes while busy are silently dropped.
  - coef_addr>=NTAPS is ignored.
  - A write and a sample accept on the same IDLE edge are both performed. The write is not visible until the next sample.
- Reset:
  - state=IDLE, all x[k]=0, all c[k]=0, acc=0, idx=0, out_valid=0, out_data=0.
  - Consequences: in_ready=1 and busy=0 from the first cycle after reset.
  - Reset mid-MAC or mid-HOLD abandons the result; no out_valid is produced for it.

Decomposition:
- Package fir_stream_pkg:
  - state enum {IDLE, MAC, FIN, HOLD}.
  - Function acc_width(DW,CW,NTAPS).
  - Function round_sat(acc, shift, DW).
- Natural sub-module fir_round_sat: combinational rounding/shift/saturate, parametrised by ACCW, DW, OUT_SHIFT. It is instantiated on the FIN register path.

Test Plan:
- Running sum: NTAPS=16, OUT_SHIFT=0, all c=1, stream samples 1..16 with out_ready=1 -> outputs 1,3,6,10,...,136. Each out_valid is exactly 17 edges after its accept.
- Impulse response: c[k]=k+1, input 1 followed by 16 zeros -> outputs 1,2,...,16 then 0.
- Saturation, positive: all c=32767, input 32767 repeated -> out_data=32767 from the first output.
- Saturation, negative: all c=32767, input -32768 repeated -> out_data=-32768.
- Rounding: OUT_SHIFT=1, c[0]=1, others 0.
  - Input 3 -> 2.
  - Input -3 -> -1.
  - Input 4 -> 2.
- Backpressure and write-while-busy:
  - out_ready=0 for 10 cycles in HOLD -> out_valid/out_data stable, in_ready=0.
  - coef_we pulsed during MAC -> coefficients unchanged; the next result matches the old coefficients.
- Reset mid-MAC: assert rst 5 cycles after accept -> out_valid never rises for that sample. Delay line and coefficients read 0, so the next sample with no new writes gives 0.
